// File: rtl/serial_frame_tx.sv
// Parallel-to-serial framing transmitter: start bit, data MSB first, optional parity, one stop bit.
// Feeds a serial-in shift register; the line idles high and is driven only from captured state.
module serial_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              so,
    output logic              busy,
    output logic              frame_done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    function automatic logic calc_parity(input logic [DATA_W-1:0] d);
        calc_parity = (PARITY_ODD != 0) ? ~(^d) : (^d);
    endfunction

    state_t            state_r, state_s;
    logic [TW-1:0]     timer_r, timer_s;
    logic [BW-1:0]     bit_cnt_r, bit_cnt_s;
    logic [DATA_W-1:0] shreg_r, shreg_s;
    logic              par_r, par_s;
    logic              so_r, so_s;
    logic              busy_r, busy_s;
    logic              done_r, done_s;
    logic              bit_end_s;
    logic              ready_s;
    logic              accept_s;

    assign bit_end_s  = (timer_r == TIMER_LAST);
    assign ready_s    = rst & ((state_r == IDLE) | ((state_r == STOP) & bit_end_s));
    assign accept_s   = tx_valid & ready_s;
    assign tx_ready   = ready_s;
    assign so         = so_r;
    assign busy       = busy_r;
    assign frame_done = done_r;

    // Next-state, next-line-value and datapath updates for the framing FSM.
    always_comb begin
        state_s   = state_r;
        timer_s   = bit_end_s ? {TW{1'b0}} : (timer_r + {{(TW-1){1'b0}}, 1'b1});
        bit_cnt_s = bit_cnt_r;
        shreg_s   = shreg_r;
        par_s     = par_r;
        so_s      = so_r;
        done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                timer_s = {TW{1'b0}};
                if (accept_s) begin
                    state_s = START;
                    shreg_s = tx_data;
                    par_s   = calc_parity(tx_data);
                    so_s    = 1'b0;
                end else begin
                    so_s = 1'b1;
                end
            end
            START: begin
                if (bit_end_s) begin
                    state_s   = DATA;
                    so_s      = shreg_r[DATA_W-1];
                    shreg_s   = shreg_r << 1;
                    bit_cnt_s = {BW{1'b0}};
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (bit_end_s) begin
                    if (bit_cnt_r == BIT_LAST) begin
                        if (PARITY_EN != 0) begin
                            state_s = PARITY;
                            so_s    = par_r;
                        end else begin
                            state_s = STOP;
                            so_s    = 1'b1;
                        end
                    end else begin
                        so_s      = shreg_r[DATA_W-1];
                        shreg_s   = shreg_r << 1;
                        bit_cnt_s = bit_cnt_r + {{(BW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_s = DATA;
                end
            end
            PARITY: begin
                if (bit_end_s) begin
                    state_s = STOP;
                    so_s    = 1'b1;
                end else begin
                    state_s = PARITY;
                end
            end
            STOP: begin
                if (bit_end_s) begin
                    done_s = 1'b1;
                    // Back-to-back accept skips IDLE so no idle bit separates frames.
                    if (accept_s) begin
                        state_s = START;
                        shreg_s = tx_data;
                        par_s   = calc_parity(tx_data);
                        so_s    = 1'b0;
                    end else begin
                        state_s = IDLE;
                        so_s    = 1'b1;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            default: begin
                state_s = IDLE;
                timer_s = {TW{1'b0}};
                so_s    = 1'b1;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= IDLE;
            timer_r   <= {TW{1'b0}};
            bit_cnt_r <= {BW{1'b0}};
            shreg_r   <= {DATA_W{1'b0}};
            par_r     <= 1'b0;
            so_r      <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            timer_r   <= timer_s;
            bit_cnt_r <= bit_cnt_s;
            shreg_r   <= shreg_s;
            par_r     <= par_s;
            so_r      <= so_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

endmodule
